// File: rtl/pulsegen_pkg.sv
// Shared types for the pulsegen profile sequencer: FSM states, table entry payload, entry check.
package pulsegen_pkg;

  localparam int unsigned PG_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic [31:0]         period;
    logic [31:0]         width;
    logic [PG_CNT_W-1:0] count;
  } pg_entry_t;

  // An entry is runnable only if written, non-degenerate and width strictly below period
  function automatic logic entry_ok(input logic valid, input pg_entry_t e);
    return valid && (e.period != '0) && (e.width != '0) &&
           (e.width < e.period) && (e.count != '0);
  endfunction

endpackage

// File: rtl/pulsegen_seq_table.sv
// Profile table: N entries with per-entry valid bits, one write port, one combinational read port.
module pulsegen_seq_table
  import pulsegen_pkg::*;
#(
  parameter  int unsigned NUM_ENTRIES = 8,
  localparam int unsigned AW          = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          aresetn,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  pg_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output pg_entry_t     rd_data_c,
  output logic          rd_valid_c
);

  pg_entry_t              mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;

  // Valid bits: cleared by reset, set by an accepted write
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  // Entry storage has no reset so table contents survive aresetn
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c  = mem[rd_addr];
  assign rd_valid_c = valid[rd_addr];

endmodule

// File: rtl/pulsegen_seq_ctrl.sv
// Profile sequencer: walks the entry table and drives one pulsegen so each entry emits 'count' pulses.
module pulsegen_seq_ctrl
  import pulsegen_pkg::*;
#(
  parameter  int unsigned NUM_ENTRIES    = 8,
  parameter  int unsigned CNT_W          = PG_CNT_W,
  parameter  int unsigned TIMEOUT_MARGIN = 16,
  localparam int unsigned AW             = $clog2(NUM_ENTRIES),
  localparam int unsigned NW             = AW + 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [31:0]      tbl_period,
  input  logic [31:0]      tbl_width,
  input  logic [CNT_W-1:0] tbl_count,
  input  logic [NW-1:0]    num_entries,
  input  logic             loop_en,
  input  logic             run,
  input  logic             abort,
  input  logic             pg_pulse,
  output logic             pg_start,
  output logic             pg_config_valid,
  output logic [31:0]      pg_period,
  output logic [31:0]      pg_width,
  output logic             busy,
  output logic [AW-1:0]    cur_entry,
  output logic             done,
  output logic             err,
  output logic             tbl_wr_rej
);

  seq_state_e       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [31:0]      timer_q, timer_d;
  logic             run_q;
  logic             pulse_q;

  logic             start_d, cfg_valid_d, done_d, err_d;
  logic [31:0]      period_d, width_d;

  pg_entry_t        wr_entry_c;
  pg_entry_t        ent_c;
  logic             ent_valid_c;
  logic             run_rise_c, pulse_rise_c, pulse_fall_c;
  logic             num_ok_c, more_c, last_pulse_c;
  logic [32:0]      timeout_lim_c;

  assign wr_entry_c = '{period: tbl_period, width: tbl_width, count: PG_CNT_W'(tbl_count)};

  pulsegen_seq_table #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_table (
    .clk        (clk),
    .aresetn    (aresetn),
    .we         (tbl_we & ~busy),
    .wr_addr    (tbl_addr),
    .wr_data    (wr_entry_c),
    .rd_addr    (idx_q),
    .rd_data_c  (ent_c),
    .rd_valid_c (ent_valid_c)
  );

  assign run_rise_c    = run & ~run_q;
  assign pulse_rise_c  = pg_pulse & ~pulse_q;
  assign pulse_fall_c  = ~pg_pulse & pulse_q;
  assign num_ok_c      = (num_entries != '0) && (num_entries <= NW'(NUM_ENTRIES));
  assign more_c        = (NW'(idx_q) + NW'(1)) < num_entries;
  assign last_pulse_c  = pulse_cnt_q == CNT_W'(ent_c.count);
  // 33-bit sum so a period near all-ones cannot wrap the limit
  assign timeout_lim_c = {1'b0, pg_period} + 33'(TIMEOUT_MARGIN);

  // Next-state and next-output decode; abort overrides every other decision
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pulse_cnt_d = pulse_cnt_q;
    timer_d     = timer_q;
    start_d     = pg_start;
    cfg_valid_d = 1'b0;
    period_d    = pg_period;
    width_d     = pg_width;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_d = 1'b0;
        if (run_rise_c) begin
          if (num_ok_c) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (entry_ok(ent_valid_c, ent_c)) begin
          period_d    = ent_c.period;
          width_d     = ent_c.width;
          cfg_valid_d = 1'b1;
          start_d     = 1'b1;
          pulse_cnt_d = '0;
          timer_d     = '0;
          state_d     = ST_RUN;
        end else begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_pulse_c && pulse_fall_c) begin
          state_d = ST_NEXT;
        end else if (pulse_rise_c) begin
          pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
          timer_d     = '0;
        end else if ({1'b0, timer_q} > timeout_lim_c) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_NEXT: begin
        if (more_c) begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_LOAD;
        end else if (loop_en) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        start_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      start_d     = 1'b0;
      cfg_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end
  end

  // State, datapath and registered outputs; busy/cur_entry track the state they describe
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      pulse_cnt_q     <= '0;
      timer_q         <= '0;
      run_q           <= 1'b0;
      pulse_q         <= 1'b0;
      pg_start        <= 1'b0;
      pg_config_valid <= 1'b0;
      pg_period       <= '0;
      pg_width        <= '0;
      busy            <= 1'b0;
      cur_entry       <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      tbl_wr_rej      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      pulse_cnt_q     <= pulse_cnt_d;
      timer_q         <= timer_d;
      run_q           <= run;
      pulse_q         <= pg_pulse;
      pg_start        <= start_d;
      pg_config_valid <= cfg_valid_d;
      pg_period       <= period_d;
      pg_width        <= width_d;
      busy            <= (state_d != ST_IDLE);
      cur_entry       <= idx_d;
      done            <= done_d;
      err             <= err_d;
      tbl_wr_rej      <= tbl_we & busy;
    end
  end

endmodule

// File: tb/tb_pulsegen_seq_ctrl.sv
// Bench for pulsegen_seq_ctrl with a behavioural pulsegen and a table-level reference model.
module tb_pulsegen_seq_ctrl;

  localparam int MAXS = 1024;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        tbl_we = 1'b0;
  logic [2:0]  tbl_addr = '0;
  logic [31:0] tbl_period = '0;
  logic [31:0] tbl_width = '0;
  logic [15:0] tbl_count = '0;
  logic [3:0]  num_entries = '0;
  logic        loop_en = 1'b0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        pg_pulse = 1'b0;
  logic        pg_start, pg_config_valid, busy, done, err, tbl_wr_rej;
  logic [31:0] pg_period, pg_width;
  logic [2:0]  cur_entry;

  logic        kill = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Bench copy of what the table should hold
  int          tb_per [8];
  int          tb_wid [8];
  int          tb_cnt [8];
  bit          tb_val [8];

  // Monitor record, indexed by config strobe number
  int          cv_total = 0;
  int          cv_cycles = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          rej_cnt = 0;
  int          seg [MAXS];
  int          ce_at [MAXS];
  int          per_at [MAXS];
  bit          cv_prev = 1'b0;
  bit          pulse_prev = 1'b0;

  // 10 MHz clock
  always #50 clk = ~clk;

  pulsegen_seq_ctrl dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .tbl_we          (tbl_we),
    .tbl_addr        (tbl_addr),
    .tbl_period      (tbl_period),
    .tbl_width       (tbl_width),
    .tbl_count       (tbl_count),
    .num_entries     (num_entries),
    .loop_en         (loop_en),
    .run             (run),
    .abort           (abort),
    .pg_pulse        (pg_pulse),
    .pg_start        (pg_start),
    .pg_config_valid (pg_config_valid),
    .pg_period       (pg_period),
    .pg_width        (pg_width),
    .busy            (busy),
    .cur_entry       (cur_entry),
    .done            (done),
    .err             (err),
    .tbl_wr_rej      (tbl_wr_rej)
  );

  // Behavioural pulsegen: restart at phase 0 on config_valid, high for width of every period
  int pm_cnt = 0;
  int pm_per = 1;
  int pm_wid = 0;
  always @(posedge clk) begin
    if (!pg_start) begin
      pm_cnt   <= 0;
      pg_pulse <= 1'b0;
    end else if (pg_config_valid) begin
      pm_per   <= int'(pg_period);
      pm_wid   <= int'(pg_width);
      pm_cnt   <= 1;
      pg_pulse <= !kill;
    end else begin
      pg_pulse <= !kill && (pm_cnt < pm_wid);
      pm_cnt   <= (pm_cnt + 1 >= pm_per) ? 0 : pm_cnt + 1;
    end
  end

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    if (pg_config_valid) begin
      cv_cycles++;
      if (!cv_prev) begin
        if (cv_total < MAXS) begin
          ce_at[cv_total]  = int'(cur_entry);
          per_at[cv_total] = int'(pg_period);
          seg[cv_total]    = 0;
        end
        cv_total++;
      end
    end
    cv_prev = pg_config_valid;
    if (pg_pulse && !pulse_prev && cv_total > 0 && cv_total <= MAXS) seg[cv_total-1]++;
    pulse_prev = pg_pulse;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (tbl_wr_rej) rej_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_entry(input int a, input int p, input int w, input int c, input bit upd);
    tbl_we     = 1'b1;
    tbl_addr   = 3'(a);
    tbl_period = 32'(p);
    tbl_width  = 32'(w);
    tbl_count  = 16'(c);
    tick(1);
    tbl_we = 1'b0;
    if (upd) begin
      tb_per[a] = p;
      tb_wid[a] = w;
      tb_cnt[a] = c;
      tb_val[a] = 1'b1;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(2);
    run = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Start a sequence and compare it against the table-level expectation
  task automatic run_seq(input string tag);
    int n_exp = 0;
    bit e_err = 1'b0;
    int s_cv, s_cvc, s_done, s_err;
    if (num_entries == 4'd0 || num_entries > 4'd8) begin
      e_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(num_entries); i++) begin
        if (!tb_val[i] || tb_per[i] == 0 || tb_wid[i] == 0 ||
            tb_wid[i] >= tb_per[i] || tb_cnt[i] == 0) begin
          e_err = 1'b1;
          break;
        end
        n_exp++;
      end
    end
    s_cv   = cv_total;
    s_cvc  = cv_cycles;
    s_done = done_cnt;
    s_err  = err_cnt;
    pulse_run();
    wait_idle(tag);
    tick(3);
    check({tag, "_strobes"}, 64'(cv_total - s_cv), 64'(n_exp));
    check({tag, "_strobe_cycles"}, 64'(cv_cycles - s_cvc), 64'(n_exp));
    check({tag, "_err"}, 64'(err_cnt - s_err), 64'(e_err));
    check({tag, "_done"}, 64'(done_cnt - s_done), 64'(!e_err));
    check({tag, "_start_low"}, 64'(pg_start), 64'd0);
    for (int k = 0; k < n_exp; k++) begin
      if (s_cv + k < MAXS) begin
        check({tag, "_pulses"}, 64'(seg[s_cv+k]), 64'(tb_cnt[k]));
        check({tag, "_entry"}, 64'(ce_at[s_cv+k]), 64'(k));
        check({tag, "_period"}, 64'(per_at[s_cv+k]), 64'(tb_per[k]));
      end
    end
  endtask

  initial begin
    int n;
    int s_cv, s_done, s_err, s_rej;
    for (int i = 0; i < 8; i++) begin
      tb_per[i] = 0; tb_wid[i] = 0; tb_cnt[i] = 0; tb_val[i] = 1'b0;
    end

    // Reset state
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_start", 64'(pg_start), 64'd0);
    check("rst_cfg_valid", 64'(pg_config_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_wr_rej", 64'(tbl_wr_rej), 64'd0);
    check("rst_cur_entry", 64'(cur_entry), 64'd0);
    check("rst_period", 64'(pg_period), 64'd0);
    check("rst_width", 64'(pg_width), 64'd0);
    aresetn = 1'b1;
    tick(2);

    // Two-entry profile, no loop
    write_entry(0, 100, 50, 3, 1'b1);
    write_entry(1, 40, 10, 2, 1'b1);
    num_entries = 4'd2;
    run_seq("basic");

    // Looping profile, then abort in the middle of RUN
    loop_en = 1'b1;
    s_cv = cv_total; s_done = done_cnt; s_err = err_cnt;
    pulse_run();
    n = 0;
    while (cv_total - s_cv < 5 && n < 5000) begin
      tick(1);
      n++;
    end
    check("loop_strobes", 64'(cv_total - s_cv >= 5), 64'd1);
    for (int k = 0; k < 5; k++) check("loop_entry", 64'(ce_at[s_cv+k]), 64'(k % 2));
    check("loop_pulses0", 64'(seg[s_cv]), 64'd3);
    check("loop_pulses1", 64'(seg[s_cv+1]), 64'd2);
    tick(20);
    abort = 1'b1;
    tick(1);
    check("abort_start", 64'(pg_start), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    abort = 1'b0;
    loop_en = 1'b0;
    tick(5);
    check("abort_no_done", 64'(done_cnt - s_done), 64'd0);
    check("abort_no_err", 64'(err_cnt - s_err), 64'd0);

    // width >= period at entry 1: entry 0 completes, then err
    write_entry(1, 40, 40, 1, 1'b1);
    run_seq("bad_entry");

    // Write while busy is rejected and leaves the table untouched
    write_entry(1, 40, 10, 2, 1'b1);
    s_rej = rej_cnt;
    pulse_run();
    tick(5);
    write_entry(0, 20, 5, 1, 1'b0);
    tick(2);
    check("wr_rej_pulse", 64'(rej_cnt - s_rej), 64'd1);
    wait_idle("wr_rej_seq");
    tick(3);
    run_seq("rerun_old");

    // Timeout: no pulse edges at all; 77 silent cycles plus the registered err output
    write_entry(0, 60, 30, 2, 1'b1);
    num_entries = 4'd1;
    kill = 1'b1;
    s_err = err_cnt;
    pulse_run();
    n = 0;
    while (!pg_start && n < 100) begin
      tick(1);
      n++;
    end
    check("timeout_started", 64'(pg_start), 64'd1);
    n = 0;
    while (!err && n < 300) begin
      tick(1);
      n++;
    end
    check("timeout_latency", 64'(n), 64'd78);
    tick(3);
    check("timeout_err_once", 64'(err_cnt - s_err), 64'd1);
    check("timeout_idle", 64'(busy), 64'd0);
    kill = 1'b0;

    // Reset mid-RUN clears valid bits; a later run errors out
    write_entry(0, 100, 50, 3, 1'b1);
    write_entry(1, 40, 10, 2, 1'b1);
    num_entries = 4'd2;
    pulse_run();
    tick(50);
    aresetn = 1'b0;
    tick(1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_start", 64'(pg_start), 64'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) tb_val[i] = 1'b0;
    tick(2);
    run_seq("after_reset");

    // run and abort together: stays idle
    write_entry(0, 100, 50, 3, 1'b1);
    write_entry(1, 40, 10, 2, 1'b1);
    s_cv = cv_total;
    abort = 1'b1;
    run = 1'b1;
    tick(3);
    check("run_abort_busy", 64'(busy), 64'd0);
    abort = 1'b0;
    tick(2);
    run = 1'b0;
    tick(2);
    check("run_abort_still_idle", 64'(busy), 64'd0);
    check("run_abort_no_strobe", 64'(cv_total - s_cv), 64'd0);

    // Out-of-range entry counts
    num_entries = 4'd0;
    run_seq("num_zero");
    num_entries = 4'd9;
    run_seq("num_nine");

    // Randomized tables and lengths
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 8; i++) begin
        int p, w, c;
        p = int'($urandom_range(40, 8));
        w = int'($urandom_range(p - 5, 1));
        c = int'($urandom_range(4, 1));
        if ($urandom_range(7, 0) == 0) begin
          case ($urandom_range(3, 0))
            0:       p = 0;
            1:       w = 0;
            2:       w = p;
            default: c = 0;
          endcase
        end
        write_entry(i, p, w, c, 1'b1);
      end
      num_entries = 4'($urandom_range(8, 1));
      run_seq("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
